sat_chan_sched: RTL and testbench
=================================

Name: sat_chan_sched

Overview:
- Configuration scheduler for a bank of satellite channel datapaths.
- Host writes per-channel Doppler, code-rate, gain and C/A select into shadow registers.
- On a commit request, all shadows copy to the active outputs together, exactly at the next code-epoch boundary.
- The epoch boundary is derived by counting sample strobes, so every channel retunes on the same sample.

Parameters:
- NUM_CHAN, 8, number of satellite channels driven.
- EPOCH_LEN, 16368, samples per epoch (1 ms at 16.368 Msps); must be >= 2.
- CHAN_W, $clog2(NUM_CHAN) (min 1), width of channel index.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- dv_in  in  1  sample strobe, same strobe that feeds the channels.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config write accepted when high with cfg_valid.
- cfg_chan  in  CHAN_W  target channel.
- cfg_field  in  2  0=dop_freq, 1=code_freq, 2=gain (data[15:0]), 3=ca_sel (data[5:0]) plus enable (data[8]).
- cfg_data  in  32  write data.
- cfg_err  out  1  one-cycle pulse: write to channel >= NUM_CHAN was dropped.
- commit_req  in  1  arm a commit at the next epoch.
- commit_pend  out  1  commit armed, not yet applied.
- epoch_out  out  1  one-cycle pulse on each epoch boundary.
- epoch_cnt  out  32  epochs elapsed since reset, wraps at 2^32.
- dop_freq  out  NUM_CHAN*32  active Doppler words, channel k at [32k+:32].
- code_freq  out  NUM_CHAN*32  active code-rate words.
- gain  out  NUM_CHAN*16  active gains.
- ca_sel  out  NUM_CHAN*6  active PRN selects.
- chan_en  out  NUM_CHAN  active channel enables.

Behaviour:
- Reset (asynchronous assert, released on a clk edge): all shadow and active registers, sample counter, epoch_cnt, epoch_out, cfg_err and commit_pend go to 0. FSM goes to IDLE.
- Sample counter
  - Increments on each clk with dv_in=1.
  - At count EPOCH_LEN-1 with dv_in=1 it wraps to 0, and epoch_out is registered high for exactly the next cycle.
  - epoch_cnt increments on that same edge.
  - The counter never stalls and is unaffected by cfg or commit activity.
- FSM states: IDLE, ARMED.
  - IDLE: cfg_ready=1. commit_req=1 -> ARMED, commit_pend=1 from the next cycle.
  - ARMED: cfg_ready=0, so shadows are frozen. commit_req is ignored. On the epoch edge (the edge that raises epoch_out), all shadows copy to the active outputs, the FSM returns to IDLE and commit_pend clears. New active values and epoch_out therefore appear in the same cycle.
- Writes
  - Accepted when cfg_valid & cfg_ready. The shadow field updates on that edge.
  - gain takes data[15:0]. ca_sel takes data[5:0] and en takes data[8]; both update on the same write.
  - cfg_chan >= NUM_CHAN: the handshake completes, no register changes, cfg_err pulses 1 cycle later.
- Simultaneous events
  - cfg write and commit_req in the same IDLE cycle: the write lands in the shadow first, then the commit is armed, so that write is included.
  - commit_req on the same edge as an epoch while IDLE: the commit waits for the following epoch. The current epoch is never used.
- Active outputs change only on a commit epoch edge. Between commits they are stable regardless of writes.
- Reset asserted while ARMED: the pending commit is discarded and outputs go to 0.
- Latency: write->shadow 1 edge. Commit->active at the first epoch edge strictly after the commit_req edge.

Test Plan:
- Reset, then 16368 dv_in pulses -> epoch_out high for exactly one cycle after the 16368th strobe. epoch_cnt=1 and all outputs remain 0.
- Write ch2 dop_freq=0x0000_1234, ch2 field3 data=0x105, then commit_req -> commit_pend=1. At the next epoch, dop_freq[2]=0x1234, ca_sel[2]=5, chan_en[2]=1, all in the same cycle as epoch_out. Commit_pend=0 after.
- While ARMED, drive cfg_valid with ch0 gain=0x7FFF -> cfg_ready=0, no acceptance. After commit, gain[0] is unchanged; the held write is accepted the cycle after return to IDLE.
- Write cfg_chan=NUM_CHAN (8) -> handshake completes, cfg_err pulses once, no output changes after a subsequent commit.
- commit_req on the same edge as an epoch -> outputs unchanged at that epoch and update at the following epoch (16368 strobes later).
- Arm a commit, assert reset mid-ARMED, release, run 2 epochs -> all outputs stay 0 and commit_pend=0.

Source files
------------

// File: rtl/sat_chan_sched.sv
// Epoch-aligned configuration scheduler for a bank of satellite channel datapaths.
// Host writes go to shadow registers; a commit copies every shadow to the outputs on one epoch edge.
module sat_chan_sched #(
  parameter int unsigned NUM_CHAN  = 8,
  parameter int unsigned EPOCH_LEN = 16368,
  parameter int unsigned CHAN_W    = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     dv_in,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [CHAN_W-1:0]        cfg_chan,
  input  logic [1:0]               cfg_field,
  input  logic [31:0]              cfg_data,
  output logic                     cfg_err,
  input  logic                     commit_req,
  output logic                     commit_pend,
  output logic                     epoch_out,
  output logic [31:0]              epoch_cnt,
  output logic [NUM_CHAN*32-1:0]   dop_freq,
  output logic [NUM_CHAN*32-1:0]   code_freq,
  output logic [NUM_CHAN*16-1:0]   gain,
  output logic [NUM_CHAN*6-1:0]    ca_sel,
  output logic [NUM_CHAN-1:0]      chan_en
);

  localparam int unsigned CNT_W = $clog2(EPOCH_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EPOCH_LEN - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ARMED = 1'b1;

  typedef struct packed {
    logic [31:0] dop;
    logic [31:0] code;
    logic [15:0] gain;
    logic [5:0]  ca;
    logic        en;
  } chan_cfg_t;

  chan_cfg_t [NUM_CHAN-1:0] shadow_q;
  chan_cfg_t [NUM_CHAN-1:0] active_q;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [0:0]       state_q, state_d;
  logic             epoch_q;
  logic [31:0]      epoch_cnt_q;
  logic             err_q;

  logic epoch_hit_c;
  logic wr_c;
  logic chan_ok_c;
  logic commit_c;

  assign epoch_hit_c = dv_in && (cnt_q == CNT_LAST);
  assign wr_c        = cfg_valid && (state_q == ST_IDLE);
  assign chan_ok_c   = 32'(cfg_chan) < NUM_CHAN;

  // Sample counter: free-running on strobes, wraps at the epoch boundary.
  always_comb begin
    cnt_d = cnt_q;
    if (dv_in) begin
      cnt_d = epoch_hit_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Commit FSM next-state.
  always_comb begin
    state_d  = state_q;
    commit_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (commit_req) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (epoch_hit_c) begin
          state_d  = ST_IDLE;
          commit_c = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      epoch_q     <= 1'b0;
      epoch_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      epoch_q <= epoch_hit_c;
      if (epoch_hit_c) epoch_cnt_q <= epoch_cnt_q + 32'd1;
      err_q   <= wr_c && !chan_ok_c;
    end
  end

  // Shadow bank: out-of-range channels complete the handshake but write nothing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_q <= '0;
    end else if (wr_c && chan_ok_c) begin
      case (cfg_field)
        2'd0: shadow_q[cfg_chan].dop  <= cfg_data;
        2'd1: shadow_q[cfg_chan].code <= cfg_data;
        2'd2: shadow_q[cfg_chan].gain <= cfg_data[15:0];
        default: begin
          shadow_q[cfg_chan].ca <= cfg_data[5:0];
          shadow_q[cfg_chan].en <= cfg_data[8];
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_q <= '0;
    end else if (commit_c) begin
      active_q <= shadow_q;
    end
  end

  assign cfg_ready   = (state_q == ST_IDLE);
  assign commit_pend = (state_q == ST_ARMED);
  assign cfg_err     = err_q;
  assign epoch_out   = epoch_q;
  assign epoch_cnt   = epoch_cnt_q;

  // Flatten the active bank onto the per-channel output buses.
  always_comb begin
    dop_freq  = '0;
    code_freq = '0;
    gain      = '0;
    ca_sel    = '0;
    chan_en   = '0;
    for (int k = 0; k < int'(NUM_CHAN); k++) begin
      dop_freq[32*k +: 32]  = active_q[k].dop;
      code_freq[32*k +: 32] = active_q[k].code;
      gain[16*k +: 16]      = active_q[k].gain;
      ca_sel[6*k +: 6]      = active_q[k].ca;
      chan_en[k]            = active_q[k].en;
    end
  end

endmodule

// File: tb/tb_sat_chan_sched.sv
// Self-checking bench for sat_chan_sched: spec-level model compared every cycle plus directed literal checks.
module tb_sat_chan_sched;

  localparam int NC = 6;
  localparam int EL = 1023;
  localparam int CW = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              dv_in = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [CW-1:0]     cfg_chan = '0;
  logic [1:0]        cfg_field = '0;
  logic [31:0]       cfg_data = '0;
  logic              cfg_err;
  logic              commit_req = 1'b0;
  logic              commit_pend;
  logic              epoch_out;
  logic [31:0]       epoch_cnt;
  logic [NC*32-1:0]  dop_freq;
  logic [NC*32-1:0]  code_freq;
  logic [NC*16-1:0]  gain;
  logic [NC*6-1:0]   ca_sel;
  logic [NC-1:0]     chan_en;

  int n_cmp = 0;
  int n_bad = 0;

  sat_chan_sched #(.NUM_CHAN(NC), .EPOCH_LEN(EL), .CHAN_W(CW)) dut (
    .clk(clk), .reset(rst_n), .dv_in(dv_in),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_chan(cfg_chan),
    .cfg_field(cfg_field), .cfg_data(cfg_data), .cfg_err(cfg_err),
    .commit_req(commit_req), .commit_pend(commit_pend),
    .epoch_out(epoch_out), .epoch_cnt(epoch_cnt),
    .dop_freq(dop_freq), .code_freq(code_freq), .gain(gain),
    .ca_sel(ca_sel), .chan_en(chan_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: strobe count, pending flag, shadow and active tables.
  int          m_cnt;
  bit          m_ep, m_armed, m_err;
  logic [31:0] m_ecnt;
  logic [31:0] sh_dop [NC], sh_code [NC], a_dop [NC], a_code [NC];
  logic [15:0] sh_gain [NC], a_gain [NC];
  logic [5:0]  sh_ca [NC], a_ca [NC];
  bit          sh_en [NC], a_en [NC];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0; m_ep <= 0; m_armed <= 0; m_err <= 0; m_ecnt <= '0;
      for (int k = 0; k < NC; k++) begin
        sh_dop[k] <= '0; sh_code[k] <= '0; sh_gain[k] <= '0; sh_ca[k] <= '0; sh_en[k] <= 0;
        a_dop[k]  <= '0; a_code[k]  <= '0; a_gain[k]  <= '0; a_ca[k]  <= '0; a_en[k]  <= 0;
      end
    end else begin
      automatic bit hit = dv_in && (m_cnt == EL - 1);
      automatic bit acc = cfg_valid && !m_armed;
      automatic int ch  = int'(cfg_chan);
      m_ep <= hit;
      if (hit) m_ecnt <= m_ecnt + 1;
      if (dv_in) m_cnt <= hit ? 0 : m_cnt + 1;
      m_err <= acc && (ch >= NC);
      if (acc && ch < NC) begin
        case (cfg_field)
          2'd0: sh_dop[ch]  <= cfg_data;
          2'd1: sh_code[ch] <= cfg_data;
          2'd2: sh_gain[ch] <= cfg_data[15:0];
          default: begin sh_ca[ch] <= cfg_data[5:0]; sh_en[ch] <= cfg_data[8]; end
        endcase
      end
      if (m_armed && hit) begin
        for (int k = 0; k < NC; k++) begin
          a_dop[k] <= sh_dop[k]; a_code[k] <= sh_code[k]; a_gain[k] <= sh_gain[k];
          a_ca[k] <= sh_ca[k]; a_en[k] <= sh_en[k];
        end
        m_armed <= 0;
      end else if (!m_armed && commit_req) begin
        m_armed <= 1;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      automatic logic [NC*32-1:0] e_dop = '0, e_code = '0;
      automatic logic [NC*16-1:0] e_gain = '0;
      automatic logic [NC*6-1:0]  e_ca = '0;
      automatic logic [NC-1:0]    e_en = '0;
      for (int k = 0; k < NC; k++) begin
        e_dop[32*k +: 32] = a_dop[k]; e_code[32*k +: 32] = a_code[k];
        e_gain[16*k +: 16] = a_gain[k]; e_ca[6*k +: 6] = a_ca[k]; e_en[k] = a_en[k];
      end
      chk("epoch_out", 256'(epoch_out), 256'(m_ep));
      chk("epoch_cnt", 256'(epoch_cnt), 256'(m_ecnt));
      chk("cfg_ready", 256'(cfg_ready), 256'(!m_armed));
      chk("commit_pend", 256'(commit_pend), 256'(m_armed));
      chk("cfg_err", 256'(cfg_err), 256'(m_err));
      chk("dop_freq", 256'(dop_freq), 256'(e_dop));
      chk("code_freq", 256'(code_freq), 256'(e_code));
      chk("gain", 256'(gain), 256'(e_gain));
      chk("ca_sel", 256'(ca_sel), 256'(e_ca));
      chk("chan_en", 256'(chan_en), 256'(e_en));
    end
  end

  task automatic wr(input int ch, input int fld, input logic [31:0] d);
    cfg_valid = 1'b1; cfg_chan = CW'(ch); cfg_field = 2'(fld); cfg_data = d;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_epoch(input string name);
    for (int i = 0; i < 2 * EL + 8; i++) begin
      @(negedge clk);
      if (epoch_out) return;
    end
    n_cmp++; n_bad++;
    $display("FAIL %s: epoch_out not seen within %0d cycles", name, 2 * EL + 8);
  endtask

  initial begin
    int s, c;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_epoch_cnt", 256'(epoch_cnt), 256'd0);
    chk("rst_cfg_ready", 256'(cfg_ready), 256'd1);
    chk("rst_dop", 256'(dop_freq), 256'd0);

    // First epoch with gapped strobes: boundary follows strobe count, not cycles.
    s = 0; c = 0;
    while (s < EL) begin
      dv_in = (c % 4 != 3);
      if (dv_in) s++;
      c++;
      @(negedge clk);
    end
    chk("ep1_pulse", 256'(epoch_out), 256'd1);
    chk("ep1_cnt", 256'(epoch_cnt), 256'd1);
    dv_in = 1'b0;
    @(negedge clk);
    chk("ep1_pulse_end", 256'(epoch_out), 256'd0);
    chk("ep1_outputs_zero", 256'({chan_en, ca_sel, gain}), 256'd0);
    dv_in = 1'b1;

    // Writes, last one issued together with commit_req.
    wr(2, 0, 32'h0000_1234);
    wr(2, 3, 32'h0000_0105);
    commit_req = 1'b1;
    wr(1, 2, 32'h0000_0055);
    commit_req = 1'b0;
    chk("armed_pend", 256'(commit_pend), 256'd1);
    chk("armed_ready", 256'(cfg_ready), 256'd0);

    // Held write while ARMED must not land before the commit.
    cfg_valid = 1'b1; cfg_chan = 3'd0; cfg_field = 2'd2; cfg_data = 32'h0000_7FFF;
    wait_epoch("commit1");
    chk("c1_dop2", 256'(dop_freq[64 +: 32]), 256'h1234);
    chk("c1_ca2", 256'(ca_sel[12 +: 6]), 256'd5);
    chk("c1_en2", 256'(chan_en[2]), 256'd1);
    chk("c1_gain1", 256'(gain[16 +: 16]), 256'h55);
    chk("c1_gain0", 256'(gain[0 +: 16]), 256'd0);
    chk("c1_pend", 256'(commit_pend), 256'd0);
    @(negedge clk);
    cfg_valid = 1'b0;

    // Out-of-range channels.
    wr(6, 0, 32'hDEAD_BEEF);
    chk("err_pulse", 256'(cfg_err), 256'd1);
    wr(7, 3, 32'h0000_013F);
    chk("err_pulse2", 256'(cfg_err), 256'd1);
    @(negedge clk);
    chk("err_clear", 256'(cfg_err), 256'd0);

    // commit_req on the epoch edge itself waits for the following epoch.
    for (int i = 0; i < 2 * EL && m_cnt != EL - 1; i++) @(negedge clk);
    commit_req = 1'b1;
    @(negedge clk);
    commit_req = 1'b0;
    chk("edge_pulse", 256'(epoch_out), 256'd1);
    chk("edge_pend", 256'(commit_pend), 256'd1);
    chk("edge_gain0", 256'(gain[0 +: 16]), 256'd0);
    wait_epoch("commit2");
    chk("c2_gain0", 256'(gain[0 +: 16]), 256'h7FFF);
    chk("c2_pend", 256'(commit_pend), 256'd0);
    chk("c2_epoch_cnt", 256'(epoch_cnt), 256'd4);

    // Reset while ARMED discards the pending commit.
    wr(3, 0, 32'h0000_0099);
    commit_req = 1'b1;
    @(negedge clk);
    commit_req = 1'b0;
    chk("rst_armed_pend", 256'(commit_pend), 256'd1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_epoch("post_rst1");
    wait_epoch("post_rst2");
    chk("pr_dop", 256'(dop_freq), 256'd0);
    chk("pr_code", 256'(code_freq), 256'd0);
    chk("pr_misc", 256'({chan_en, ca_sel, gain}), 256'd0);
    chk("pr_pend", 256'(commit_pend), 256'd0);
    chk("pr_epoch_cnt", 256'(epoch_cnt), 256'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
